// File: rtl/sync_fifo_param_if.sv
// Purpose : handshake/data bundle between a sync_fifo_param and its producer/consumer logic.
// Latency : none; this is wiring only.
// Backpressure: carries the full/empty/almost flags and error pulses back to the requester.
// Ports   : master drives wn, rn, DATAIN and observes everything else; slave (the FIFO)
//           takes the requests and data and drives DATAOUT, count, flags and error pulses.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  wn;
    logic                  rn;
    logic [DATA_WIDTH-1:0] DATAIN;
    logic [DATA_WIDTH-1:0] DATAOUT;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_W:0]       count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wn, rn, DATAIN,
        input  DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wn, rn, DATAIN,
        output DATAOUT, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Purpose : parametrised single-clock FIFO using all DEPTH entries, with occupancy count,
//           almost-full/almost-empty thresholds and one-cycle overflow/underflow pulses.
// Latency : read data appears on DATAOUT one clock after an accepted rn; no fall-through.
// Backpressure: writes to a full FIFO are dropped (overflow pulse) unless a read is accepted in
//           the same cycle; reads from an empty FIFO are dropped (underflow pulse).
// Ports   : clock, reset (async, active-high); bus = slave side of sync_fifo_param_if.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic              clock,
    input  logic              reset,
    sync_fifo_param_if.slave  bus
);
    // Pointer index width follows DEPTH so the two can never disagree.
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0] CNT_ONE   = 1;
    localparam logic [ADDR_W:0] CNT_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_AF    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_AE    = AE_LEVEL[ADDR_W:0];

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Extra MSB on each pointer is a wrap bit; only the low ADDR_W bits address memory.
    logic [ADDR_W:0]       wptr;
    logic [ADDR_W:0]       rptr;
    logic [ADDR_W:0]       count_q;
    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full_c;
    logic empty_c;
    logic rd_ok;
    logic wr_ok;

    assign full_c  = (count_q == CNT_DEPTH);
    assign empty_c = (count_q == '0);

    assign rd_ok = bus.rn & ~empty_c;
    // A full FIFO still takes a write when the same-cycle read frees the slot being written.
    assign wr_ok = bus.wn & (~full_c | bus.rn);

    // Storage is not reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wptr[ADDR_W-1:0]] <= bus.DATAIN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            dataout_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (rd_ok) begin
                // When full with a concurrent write, wptr == rptr in the low bits; the
                // non-blocking memory write means this still returns the old entry.
                dataout_q <= mem[rptr[ADDR_W-1:0]];
                rptr      <= rptr + CNT_ONE;
            end
            if (wr_ok) begin
                wptr <= wptr + CNT_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count_q <= count_q + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count_q <= count_q - CNT_ONE;
            end
            overflow_q  <= bus.wn & full_c & ~bus.rn;
            underflow_q <= bus.rn & empty_c;
        end
    end

    assign bus.DATAOUT      = dataout_q;
    assign bus.count        = count_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = (count_q >= CNT_AF);
    assign bus.almost_empty = (count_q <= CNT_AE);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Purpose : directed self-checking bench for sync_fifo_param (DATA_WIDTH=8, DEPTH=8).
// Latency : each stimulus cycle is driven 1 ns after a rising edge and checked 1 ns after the next.
// Backpressure: exercises overflow/underflow rejection and simultaneous read/write at full/empty.
module tb_sync_fifo_param;
    logic clock;
    logic reset;

    int n_tests;
    int n_fail;

    sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(8)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(8),
        .DEPTH     (8),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; returns 1 ns after the edge that sampled it.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bus.wn     = w;
        bus.rn     = r;
        bus.DATAIN = d;
        @(posedge clock);
        #1;
        bus.wn = 1'b0;
        bus.rn = 1'b0;
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, ".dataout"}, 32'(bus.DATAOUT), 32'h0);
        check({tag, ".count"}, 32'(bus.count), 32'd0);
        check({tag, ".empty"}, 32'(bus.empty), 32'd1);
        check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'd1);
        check({tag, ".full"}, 32'(bus.full), 32'd0);
        check({tag, ".almost_full"}, 32'(bus.almost_full), 32'd0);
        check({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
        check({tag, ".underflow"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        logic [7:0] word;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        bus.wn     = 1'b0;
        bus.rn     = 1'b0;
        bus.DATAIN = 8'h00;

        // Reset values while reset is held, then after release plus an idle cycle.
        #2;
        check_idle_state("rst_held");
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        check_idle_state("rst_idle");

        // Fill with 0x11..0x88, tracking count and threshold flags at each level.
        for (int i = 1; i <= 8; i++) begin
            word = 8'(i * 8'h11);
            cyc(1'b1, 1'b0, word);
            check($sformatf("fill%0d.count", i), 32'(bus.count), 32'(i));
            check($sformatf("fill%0d.af", i), 32'(bus.almost_full), (i >= 6) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d.ae", i), 32'(bus.almost_empty), (i <= 2) ? 32'd1 : 32'd0);
        end
        check("fill.full", 32'(bus.full), 32'd1);
        check("fill.empty", 32'(bus.empty), 32'd0);

        // Drain: each word appears one clock after its rn.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d.data", i), 32'(bus.DATAOUT), 32'(8'(i * 8'h11)));
            check($sformatf("drain%0d.count", i), 32'(bus.count), 32'(8 - i));
        end
        check("drain.empty", 32'(bus.empty), 32'd1);
        check("drain.full", 32'(bus.full), 32'd0);

        // Refill, then a lone write while full is rejected with a one-cycle overflow pulse.
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 8'(i * 8'h11));
        end
        cyc(1'b1, 1'b0, 8'hAA);
        check("ovf.pulse", 32'(bus.overflow), 32'd1);
        check("ovf.count", 32'(bus.count), 32'd8);
        cyc(1'b0, 1'b0, 8'h00);
        check("ovf.clear", 32'(bus.overflow), 32'd0);

        // Full with simultaneous read/write: oldest comes out, count holds at DEPTH.
        cyc(1'b1, 1'b1, 8'h99);
        check("fullrw.data", 32'(bus.DATAOUT), 32'h11);
        check("fullrw.count", 32'(bus.count), 32'd8);
        check("fullrw.ovf", 32'(bus.overflow), 32'd0);
        check("fullrw.udf", 32'(bus.underflow), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check($sformatf("wrap%0d.data", i), 32'(bus.DATAOUT), 32'(8'(i * 8'h11)));
        end
        cyc(1'b0, 1'b1, 8'h00);
        check("wrap.last", 32'(bus.DATAOUT), 32'h99);
        check("wrap.empty", 32'(bus.empty), 32'd1);

        // Lone read while empty: underflow pulse, DATAOUT holds.
        cyc(1'b0, 1'b1, 8'h00);
        check("udf.pulse", 32'(bus.underflow), 32'd1);
        check("udf.data", 32'(bus.DATAOUT), 32'h99);
        check("udf.count", 32'(bus.count), 32'd0);
        cyc(1'b0, 1'b0, 8'h00);
        check("udf.clear", 32'(bus.underflow), 32'd0);

        // Empty with simultaneous read/write: write lands, read rejected, no fall-through.
        cyc(1'b1, 1'b1, 8'h5A);
        check("emptyrw.udf", 32'(bus.underflow), 32'd1);
        check("emptyrw.count", 32'(bus.count), 32'd1);
        check("emptyrw.data", 32'(bus.DATAOUT), 32'h99);
        cyc(1'b0, 1'b1, 8'h00);
        check("emptyrw.read", 32'(bus.DATAOUT), 32'h5A);
        check("emptyrw.empty", 32'(bus.empty), 32'd1);

        // Mid-cycle asynchronous reset with five words stored.
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
        end
        check("prerst.count", 32'(bus.count), 32'd5);
        #3;
        reset = 1'b1;
        #1;
        check_idle_state("async_rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("postrst.empty", 32'(bus.empty), 32'd1);
        cyc(1'b1, 1'b0, 8'hC3);
        check("postrst.count", 32'(bus.count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        check("postrst.data", 32'(bus.DATAOUT), 32'hC3);
        check("postrst.empty2", 32'(bus.empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; successor to the team's fixed 8x8 FIFO.
- Generalised in data width and depth.
- Allows simultaneous read and write in one cycle.
- Uses all DEPTH entries, adds occupancy count, programmable almost-full/almost-empty thresholds, and one-cycle overflow/underflow error pulses.
- Used as the standard buffering element between producer/consumer stages in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 8, number of entries; power of two, >= 2.
- ADDR_W, log2(DEPTH) = 3, derived pointer index width; not to be overridden independently.
- AF_LEVEL, DEPTH-2 = 6, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- wn  input  1  write request.
- rn  input  1  read request.
- DATAIN  input  DATA_WIDTH  write data, sampled on an accepted write.
- DATAOUT  output  DATA_WIDTH  registered read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset is asynchronous and active-high; it takes effect immediately, independent of clock.
- Values while reset is asserted: wptr = rptr = 0, count = 0, DATAOUT = 0, overflow = 0, underflow = 0.
- Therefore at reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Memory contents are not cleared by reset. Reset mid-operation discards all stored data.
- Pointers are ADDR_W+1 bits. The MSB is a wrap bit. Memory is indexed by the low ADDR_W bits; each pointer wraps DEPTH-1 -> 0 naturally.
- count is a register. full, empty, almost_full and almost_empty are combinational decodes of count.
- Read accept: rd_ok = rn & !empty.
- Write accept: wr_ok = wn & (!full | rn). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- On rd_ok:
  - DATAOUT <= mem[rptr] (the oldest entry).
  - rptr increments.
  - Read latency is one clock: data is valid on DATAOUT the cycle after rn is sampled.
- On wr_ok:
  - mem[wptr] <= DATAIN.
  - wptr increments.
- DATAOUT holds its last value on cycles with no accepted read.
- count update:
  - +1 if wr_ok & !rd_ok.
  - -1 if rd_ok & !wr_ok.
  - Unchanged if both or neither.
- Simultaneous rn & wn when empty: the write is accepted and the read is rejected (underflow pulses). There is no fall-through; the data becomes readable the next cycle.
- Simultaneous rn & wn when full: both are accepted. count stays at DEPTH and DATAOUT gets the oldest entry.
- Simultaneous rn & wn at any other level: both are accepted and count is unchanged.
- overflow <= wn & full & !rn, registered; high for exactly the cycle after the rejected request.
- underflow <= rn & empty, registered; same timing.
- A rejected request changes no state other than its error flag.
- almost_full and almost_empty may both be high when thresholds overlap; this is legal.

Test Plan:
- Reset then idle → DATAOUT=0, count=0, empty=1, almost_empty=1, full=0, no error pulses.
- Write 0x11..0x88 (8 words) → count=8, full=1, almost_full from count=6. Then read 8 → DATAOUT sequence 0x11..0x88, each one cycle after rn. Ends with empty=1.
- When full, wn alone with 0xAA → overflow pulses one cycle; count stays 8; subsequent reads show no 0xAA. When empty, rn alone → underflow pulses; DATAOUT unchanged.
- Full FIFO, wn=rn=1 with 0x99 → DATAOUT=0x11, count stays 8. After 7 more reads, the 8th read returns 0x99 (pointer wrap verified).
- Empty FIFO, wn=rn=1 with 0x5A → underflow=1, count=1. Next-cycle read gives DATAOUT=0x5A.
- Write 5 words, assert reset asynchronously mid-cycle → outputs go to reset values before the next clock edge. After release, empty=1 and the first write/read round-trips correctly.
